// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// One command is in flight at a time: IDLE accepts, ACCESS touches memory, RESP returns the result.
module data_mem_arbiter #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic             req0_we,
    input  logic [63:0]      req0_addr,
    input  logic [WIDTH-1:0] req0_wdata,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic             req1_we,
    input  logic [63:0]      req1_addr,
    input  logic [WIDTH-1:0] req1_wdata,
    output logic             req1_ready,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_rdata,
    output logic             rsp0_err,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_rdata,
    output logic             rsp1_err,

    output logic             mem_read,
    output logic             mem_write,
    output logic [63:0]      mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,

    output logic             busy
);

    // state  | meaning
    // IDLE   | arbitrate, accept one command (ready is combinational)
    // ACCESS | one-cycle memory read or write with the latched command
    // RESP   | hold response for the latched port until its rsp_ready
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [63:0] DEPTH_W = 64'(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_last_grant;
    logic               r_port;
    logic               r_we;
    logic [63:0]        r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic               r_err;
    logic [WIDTH-1:0]   r_rdata;

    logic               w_grant;
    logic               w_accept;
    logic               w_sel_we;
    logic [63:0]        w_sel_addr;
    logic [WIDTH-1:0]   w_sel_wdata;
    logic               w_in_range;
    logic               w_rsp_ready;

    // Contention goes to the port that did not win last; a lone requester always wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept    = rst_n && (r_state == IDLE) && (req0_valid || req1_valid);
    assign w_sel_we    = w_grant ? req1_we    : req0_we;
    assign w_sel_addr  = w_grant ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant ? req1_wdata : req0_wdata;
    assign w_in_range  = (w_sel_addr < DEPTH_W);
    assign w_rsp_ready = r_port ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_in_range ? ACCESS : RESP;
                end
            end
            ACCESS: w_state_nxt = RESP;
            RESP: begin
                if (w_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
            r_port       <= w_grant;
            r_we         <= w_sel_we;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_err        <= ~w_in_range;
            r_rdata      <= '0;
        end else if ((r_state == ACCESS) && !r_we) begin
            r_rdata      <= mem_rdata;
        end
    end

    // Memory strobes are decoded from the state register, so an async reset kills a write at once.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_rdata = '0;
        rsp1_rdata = '0;
        rsp0_err   = 1'b0;
        rsp1_err   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = (r_state != IDLE);

        if (w_accept) begin
            req0_ready = ~w_grant;
            req1_ready = w_grant;
        end

        if (r_state == ACCESS) begin
            mem_read  = ~r_we;
            mem_write = r_we;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
        end

        if (r_state == RESP) begin
            if (r_port) begin
                rsp1_valid = 1'b1;
                rsp1_rdata = r_rdata;
                rsp1_err   = r_err;
            end else begin
                rsp0_valid = 1'b1;
                rsp0_rdata = r_rdata;
                rsp0_err   = r_err;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed commands push expected responses,
// a negedge monitor pops and compares each accepted response.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_we, req0_ready;
    logic [63:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_we, req1_ready;
    logic [63:0] req1_addr, req1_wdata;
    logic        rsp0_valid, rsp0_ready, rsp0_err;
    logic [63:0] rsp0_rdata;
    logic        rsp1_valid, rsp1_ready, rsp1_err;
    logic [63:0] rsp1_rdata;
    logic        mem_read, mem_write, busy;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    logic [63:0] tb_mem [0:127];

    typedef struct {
        int          port;
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t q[$];

    int checks   = 0;
    int failures = 0;

    data_mem_arbiter #(.WIDTH(64), .DEPTH(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr[6:0]] <= mem_wdata;
    end
    assign mem_rdata = tb_mem[mem_addr[6:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic rv(input int p);
        return (p == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [63:0] a, input logic [63:0] wd);
        if (p == 1) begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = wd;
        end else begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = wd;
        end
    endtask

    task automatic wait_ready(input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy(p)) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        chk(name, ok, 1'b1);
        @(posedge clk); #1;
    endtask

    // Expects rsp_ready high for port p; checks ACCESS cycle contents and response latency.
    task automatic txn(input int p, input logic we, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err);
        bit ok;
        set_req(p, 1'b1, we, addr, wd);
        wait_ready(p, ok);
        chk("hs_ready", ok, 1'b1);
        if (ok) begin
            chk("other_ready", rdy(1 - p), 1'b0);
            q.push_back('{p, exp_rd, exp_err});
            @(posedge clk); #1;
            set_req(p, 1'b0, 1'b0, 64'd0, 64'd0);
            @(negedge clk);
            if (!exp_err) begin
                chk("acc_write", mem_write, we);
                chk("acc_read", mem_read, !we);
                chk("acc_addr", mem_addr, addr);
                chk("acc_wdata", mem_wdata, wd);
                chk("acc_no_rsp", rv(p), 1'b0);
                chk("acc_busy", busy, 1'b1);
                @(negedge clk);
            end
            chk("rsp_latency", rv(p), 1'b1);
            chk("rsp_no_read", mem_read, 1'b0);
            chk("rsp_no_write", mem_write, 1'b0);
            chk("rsp_addr_zero", mem_addr, 64'd0);
            @(posedge clk); #1;
        end else begin
            set_req(p, 1'b0, 1'b0, 64'd0, 64'd0);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rsp_exclusive", {63'd0, rsp0_valid & rsp1_valid}, 64'd0);
            for (int p = 0; p < 2; p++) begin
                if (rv(p) && ((p == 1) ? rsp1_ready : rsp0_ready)) begin
                    if (q.size() == 0) begin
                        chk("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("rsp_port", p, e.port);
                        chk("rsp_rdata", (p == 1) ? rsp1_rdata : rsp0_rdata, e.rdata);
                        chk("rsp_err", (p == 1) ? rsp1_err : rsp0_err, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int gp;
        for (int i = 0; i < 128; i++) tb_mem[i] = 64'd0;
        rst_n = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(0, 1'b1, 1'b0, 64'd1, 64'd0);
        set_req(1, 1'b1, 1'b0, 64'd2, 64'd0);

        // Reset: everything low even with requests pending
        repeat (3) @(negedge clk);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_rsp0", rsp0_valid, 1'b0);
        chk("rst_rsp1", rsp1_valid, 1'b0);
        set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_req(1, 1'b0, 1'b0, 64'd0, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read back
        txn(0, 1'b1, 64'd5, 64'hDEAD_BEEF, 64'd0, 1'b0);
        txn(0, 1'b0, 64'd5, 64'd0, 64'hDEAD_BEEF, 1'b0);
        txn(1, 1'b1, 64'd10, 64'hA0, 64'd0, 1'b0);
        txn(1, 1'b1, 64'd11, 64'hB1, 64'd0, 1'b0);
        txn(0, 1'b1, 64'd3, 64'h33, 64'd0, 1'b0);

        // Address boundaries
        txn(1, 1'b1, 64'd127, 64'h7F7F, 64'd0, 1'b0);
        txn(0, 1'b0, 64'd127, 64'd0, 64'h7F7F, 1'b0);
        txn(1, 1'b0, 64'd128, 64'd0, 64'd0, 1'b1);
        txn(0, 1'b1, 64'h1_0000_0005, 64'h55, 64'd0, 1'b1);
        chk("trunc_no_write", tb_mem[5], 64'hDEAD_BEEF);

        // Response back-pressure holds data and blocks the other port
        rsp0_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 64'd10, 64'd0);
        wait_ready(0, ok);
        chk("bp_hs0", ok, 1'b1);
        q.push_back('{0, 64'hA0, 1'b0});
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_req(1, 1'b1, 1'b0, 64'd11, 64'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp0_valid, 1'b1);
            chk("bp_rdata", rsp0_rdata, 64'hA0);
            chk("bp_no_ready1", req1_ready, 1'b0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        wait_ready(1, ok);
        chk("bp_hs1", ok, 1'b1);
        if (ok) q.push_back('{1, 64'hB1, 1'b0});
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 64'd0, 64'd0);
        wait_idle("bp_drain");

        // Reset during a write ACCESS
        set_req(0, 1'b1, 1'b1, 64'd3, 64'h99);
        wait_ready(0, ok);
        chk("ar_hs", ok, 1'b1);
        @(posedge clk); #1;
        chk("ar_write_on", mem_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_write_off", mem_write, 1'b0);
        chk("ar_mem_addr", mem_addr, 64'd0);
        chk("ar_mem_wdata", mem_wdata, 64'd0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_ready0", req0_ready, 1'b0);
        set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        chk("ar_rsp0", rsp0_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ar_mem3_kept", tb_mem[3], 64'h33);

        // Continuous contention alternates starting with port 0
        set_req(0, 1'b1, 1'b0, 64'd10, 64'd0);
        set_req(1, 1'b1, 1'b0, 64'd11, 64'd0);
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            gp = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin ok = 1'b1; break; end
            end
            chk("rr_hs", ok, 1'b1);
            if (ok) begin
                gp = req1_ready ? 1 : 0;
                chk("rr_grant", gp, k % 2);
                chk("rr_single", {63'd0, req0_ready & req1_ready}, 64'd0);
                q.push_back('{k % 2, (k % 2 == 1) ? 64'hB1 : 64'hA0, 1'b0});
            end
            @(posedge clk); #1;
        end
        set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
        set_req(1, 1'b0, 1'b0, 64'd0, 64'd0);
        wait_idle("rr_drain");

        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the data word width.
REQ-002 Parameter DEPTH, default 128, SHALL set the number of valid memory words; legal word addresses are 0..DEPTH-1.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 reqN_valid  input  1  (N=0,1)  SHALL mean requester N presents a command.
REQ-006 reqN_we  input  1  SHALL select write (1) or read (0).
REQ-007 reqN_addr  input  64  SHALL carry the word address.
REQ-008 reqN_wdata  input  WIDTH  SHALL carry the write data.
REQ-009 reqN_ready  output  1  SHALL be the accept strobe; the handshake completes when valid and ready are both high at a rising edge.
REQ-010 rspN_valid  output  1  SHALL mark a response for requester N.
REQ-011 rspN_ready  input  1  SHALL be the requester's response acceptance.
REQ-012 rspN_rdata  output  WIDTH  SHALL carry read data; it SHALL be 0 for writes and errors.
REQ-013 rspN_err  output  1  SHALL flag an out-of-range address.
REQ-014 mem_read, mem_write  output  1 each  SHALL drive the data memory enables.
REQ-015 mem_addr  output  64 and mem_wdata  output  WIDTH  SHALL drive the data memory address and write data.
REQ-016 mem_rdata  input  WIDTH  SHALL be the combinational read data from the memory.
REQ-017 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-019 In IDLE, reqN_ready SHALL be combinational: it SHALL be high only for the single port chosen by arbitration, and only when that port's valid is high.
REQ-020 Arbitration SHALL be round-robin.
  - A lone valid requester wins.
  - When both are valid, the port not equal to last_grant wins.
  - last_grant SHALL update on each accepted handshake.
REQ-021 On handshake the block SHALL latch port, we, addr and wdata.
  - If addr < DEPTH, next state SHALL be ACCESS.
  - Otherwise, next state SHALL be RESP with err=1 and no memory access.
REQ-022 In ACCESS, for exactly one cycle:
  - mem_addr SHALL carry the latched addr.
  - mem_read SHALL equal !we and mem_write SHALL equal we.
  - mem_wdata SHALL carry the latched wdata.
  - For reads, mem_rdata SHALL be captured at the closing edge.
  - Next state SHALL be RESP.
REQ-023 Outside ACCESS, mem_read and mem_write SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-024 In RESP, rspN_valid SHALL be high only for the latched port, with rdata and err held stable until rspN_ready is high at a rising edge; the block SHALL then return to IDLE.
REQ-025 Latency SHALL be: handshake at edge T, ACCESS in cycle T+1, response valid from cycle T+2 (T+1 for an error); peak throughput SHALL be one transaction per 3 cycles.
REQ-026 reqN_ready SHALL be 0 in ACCESS and RESP; new requests SHALL wait without being lost.
REQ-027 Address comparison SHALL use the full 64-bit unsigned address; there SHALL be no wrap-around or truncation.
REQ-028 A requester deasserting valid before its handshake SHALL have no effect, and last_grant SHALL remain unchanged.

Reset
REQ-029 On rst_n low, the block SHALL immediately enter IDLE and drive all outputs to 0.
  - last_grant SHALL be set to 1, so port 0 wins the first contention.
  - Latched command registers SHALL be cleared.
REQ-030 Reset asserted during ACCESS SHALL deassert mem_write combinationally, aborting the write; the in-flight transaction SHALL produce no response.
REQ-031 After rst_n rises, the first accept SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-032 Port 0 write, addr=5, wdata=0xDEAD_BEEF; then port 0 read, addr=5 -> mem_write high for 1 cycle; read response rdata=0xDEADBEEF, err=0, at T+2.
REQ-033 Both ports valid every cycle after reset, both reading -> grants alternate 0,1,0,1; each response goes only to the granted port.
REQ-034 Port 1 read, addr=128 -> no mem_read pulse; rsp1_valid at T+1 with err=1 and rdata=0.
REQ-035 rsp0_ready held low for 4 cycles -> rsp0_valid and rdata are stable for 4 cycles; a pending req1 receives no ready until RESP exits.
REQ-036 rst_n pulsed low during ACCESS of a write to addr=3 -> mem_write drops immediately; mem[3] is unchanged; all outputs are 0; the next contention is granted to port 0.
